// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_sb
//  Description : Parametrised register file with a per-register busy
//                scoreboard and a sequenced post-reset clear sweep.
//                S1 reserves a destination (busy <= 1), S3 writeback commits
//                data and releases it (busy <= 0). Reads are asynchronous.
//  Ports       : clk, rst_n (sync active-low)
//                S1_ReadSelect1/2 -> RF_ReadData1/2, RF_Busy1/2
//                S1_Reserve, S1_ReserveSelect  : reserve a destination
//                S3_WriteData/Select/Enable    : writeback port
//                RF_Ready                      : clear sweep finished
//  Options     : `define RF_WRITE_BYPASS_EN to forward the S3 write data
//                (and its busy release) to the read ports in the same cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module register_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] S1_ReadSelect1,
   input  logic [ADDR_W-1:0] S1_ReadSelect2,
   input  logic              S1_Reserve,
   input  logic [ADDR_W-1:0] S1_ReserveSelect,
   input  logic [DATA_W-1:0] S3_WriteData,
   input  logic [ADDR_W-1:0] S3_WriteSelect,
   input  logic              S3_WriteEnable,
   output logic [DATA_W-1:0] RF_ReadData1,
   output logic [DATA_W-1:0] RF_ReadData2,
   output logic              RF_Busy1,
   output logic              RF_Busy2,
   output logic              RF_Ready
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   sweep_cnt;
   logic [DEPTH-1:0]    busy;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_ok;
   logic                res_ok;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wa;
   logic [DATA_W-1:0]   mem_wd;

   // Entry 0 is hardwired when ZERO_REG is set, so it never takes a write
   // or a reservation.
   assign wr_ok  = (state == ST_READY) && S3_WriteEnable &&
                   !((ZERO_REG != 0) && (S3_WriteSelect == '0));
   assign res_ok = (state == ST_READY) && S1_Reserve &&
                   !((ZERO_REG != 0) && (S1_ReserveSelect == '0));

   // Single storage write port shared by the clear sweep and writeback,
   // keeping the array mappable onto a simple-dual-port RAM.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = S3_WriteSelect;
      mem_wd = S3_WriteData;
      if (rst_n) begin
         if (state == ST_CLEAR) begin
            mem_we = 1'b1;
            mem_wa = sweep_cnt;
            mem_wd = '0;
         end else if (wr_ok) begin
            mem_we = 1'b1;
         end
      end
   end

   // Storage has no reset; the sweep zeroes it after rst_n is released.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   // Control state, sweep counter and busy scoreboard.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_CLEAR;
         sweep_cnt <= '0;
         busy      <= '0;
         RF_Ready  <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               sweep_cnt <= sweep_cnt + 1'b1;
               if (&sweep_cnt) begin
                  state    <= ST_READY;
                  RF_Ready <= 1'b1;
               end
            end
            ST_READY: begin
               RF_Ready <= 1'b1;
               // Reserve is applied after the release so a same-address
               // reserve (newer producer) leaves the entry busy.
               if (wr_ok) begin
                  busy[S3_WriteSelect] <= 1'b0;
               end
               if (res_ok) begin
                  busy[S1_ReserveSelect] <= 1'b1;
               end
            end
            default: begin
               state <= ST_CLEAR;
            end
         endcase
      end
   end

   // Two identical asynchronous read ports.
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [ADDR_W-1:0] sel;
      logic [DATA_W-1:0] data;
      logic              bsy;

      assign sel = (p == 0) ? S1_ReadSelect1 : S1_ReadSelect2;

      always_comb begin
         data = '0;
         bsy  = 1'b0;
         if ((state == ST_READY) && !((ZERO_REG != 0) && (sel == '0))) begin
            data = mem[sel];
            bsy  = busy[sel];
`ifdef RF_WRITE_BYPASS_EN
            // Forward the writeback; busy reflects the post-edge value,
            // which a same-cycle reserve of this entry sets again.
            if (S3_WriteEnable && (sel == S3_WriteSelect)) begin
               data = S3_WriteData;
               bsy  = S1_Reserve && (S1_ReserveSelect == sel);
            end
`endif
         end
      end
   end

   assign RF_ReadData1 = g_port[0].data;
   assign RF_ReadData2 = g_port[1].data;
   assign RF_Busy1     = g_port[0].bsy;
   assign RF_Busy2     = g_port[1].bsy;

endmodule
`default_nettype wire

// File: tb/tb_register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_sb
//  Description : Self-checking bench for register_file_sb. Two instances run
//                on shared stimulus: one with ZERO_REG=1, one with ZERO_REG=0.
//                A behavioural model predicts every output each cycle, and
//                directed sequences pin literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_register_file_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
`ifdef RF_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] sel1, sel2, rsel, wsel;
   logic          res, we;
   logic [DW-1:0] wd;

   logic [DW-1:0] rd1_z, rd2_z, rd1_n, rd2_n;
   logic          b1_z, b2_z, b1_n, b2_n, rdy_z, rdy_n;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .S1_ReadSelect1(sel1), .S1_ReadSelect2(sel2),
      .S1_Reserve(res), .S1_ReserveSelect(rsel),
      .S3_WriteData(wd), .S3_WriteSelect(wsel), .S3_WriteEnable(we),
      .RF_ReadData1(rd1_z), .RF_ReadData2(rd2_z),
      .RF_Busy1(b1_z), .RF_Busy2(b2_z), .RF_Ready(rdy_z)
   );

   register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_nz (
      .clk(clk), .rst_n(rst_n),
      .S1_ReadSelect1(sel1), .S1_ReadSelect2(sel2),
      .S1_Reserve(res), .S1_ReserveSelect(rsel),
      .S3_WriteData(wd), .S3_WriteSelect(wsel), .S3_WriteEnable(we),
      .RF_ReadData1(rd1_n), .RF_ReadData2(rd2_n),
      .RF_Busy1(b1_n), .RF_Busy2(b2_n), .RF_Ready(rdy_n)
   );

   // ---------------- behavioural model (index 0: ZERO_REG=1, 1: ZERO_REG=0)
   logic [DW-1:0] m_mem  [2][DEPTH];
   logic          m_busy [2][DEPTH];
   bit            m_ready = 1'b0;
   int            m_cnt   = 0;
   bit            chk_en  = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         chk_en  <= 1'b1;
         m_ready <= 1'b0;
         m_cnt   <= 0;
         for (int z = 0; z < 2; z++)
            for (int i = 0; i < DEPTH; i++)
               m_busy[z][i] <= 1'b0;
      end else if (chk_en) begin
         if (!m_ready) begin
            for (int z = 0; z < 2; z++) m_mem[z][m_cnt] <= '0;
            m_cnt   <= m_cnt + 1;
            m_ready <= (m_cnt == DEPTH - 1);
         end else begin
            for (int z = 0; z < 2; z++) begin
               if (we && !(z == 0 && wsel == 0)) m_mem[z][wsel] <= wd;
               // busy ends as 1 whenever a valid reserve hits; else a write clears it
               if (res && !(z == 0 && rsel == 0))
                  m_busy[z][rsel] <= 1'b1;
               else if (we && !(z == 0 && wsel == 0) &&
                        !(res && rsel == wsel && !(z == 0 && rsel == 0)))
                  m_busy[z][wsel] <= 1'b0;
            end
            for (int z = 0; z < 2; z++)
               if (res && !(z == 0 && rsel == 0) && we && wsel != rsel &&
                   !(z == 0 && wsel == 0))
                  m_busy[z][wsel] <= 1'b0;
         end
      end
   end

   function automatic logic [DW:0] exp_rd(int z, logic [AW-1:0] sel);
      if (!m_ready) return '0;
      if (z == 0 && sel == 0) return '0;
      if (BYP && we && sel == wsel) return {res && (rsel == sel), wd};
      return {m_busy[z][sel], m_mem[z][sel]};
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [DW:0] e;
         e = exp_rd(0, sel1); check("z.rd1", rd1_z, e[DW-1:0]); check("z.b1", DW'(b1_z), DW'(e[DW]));
         e = exp_rd(0, sel2); check("z.rd2", rd2_z, e[DW-1:0]); check("z.b2", DW'(b2_z), DW'(e[DW]));
         e = exp_rd(1, sel1); check("n.rd1", rd1_n, e[DW-1:0]); check("n.b1", DW'(b1_n), DW'(e[DW]));
         e = exp_rd(1, sel2); check("n.rd2", rd2_n, e[DW-1:0]); check("n.b2", DW'(b2_n), DW'(e[DW]));
         check("z.rdy", DW'(rdy_z), DW'(m_ready));
         check("n.rdy", DW'(rdy_n), DW'(m_ready));
      end
   end

   // ---------------- directed helpers
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      we = 1'b0; res = 1'b0;
   endtask

   function automatic logic [AW-1:0] raddr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
      return AW'($urandom);
   endfunction

   task automatic sweep_and_check(input string tag);
      for (int k = 1; k <= DEPTH; k++) begin
         tick();
         if (k == DEPTH - 1) check({tag, ".ready_early"}, DW'(rdy_z), 32'd0);
         if (k == DEPTH)     check({tag, ".ready_on_time"}, DW'(rdy_z), 32'd1);
      end
   endtask

   initial begin
      rst_n = 1'b0; sel1 = '0; sel2 = '0; rsel = '0; wsel = '0; wd = '0;
      idle();
      tick(); tick();
      check("reset.ready", DW'(rdy_z), 32'd0);

      // Clear sweep with writes and reserves that must be ignored
      rst_n = 1'b1; we = 1'b1; wsel = 5; wd = 32'hDEADBEEF; res = 1'b1; rsel = 5;
      sweep_and_check("sweep");
      idle(); sel1 = 5; #1;
      check("sweep.r5", rd1_z, 32'h0);
      check("sweep.r5busy", DW'(b1_z), 32'd0);

      // Write/read and zero register
      we = 1'b1; wsel = 7; wd = 32'h12345678; tick();
      wsel = 0; wd = 32'hFFFFFFFF; tick();
      idle(); sel1 = 7; sel2 = 0; #1;
      check("wr.r7", rd1_z, 32'h12345678);
      check("wr.r0_zero", rd2_z, 32'h0);
      check("wr.r0_plain", rd2_n, 32'hFFFFFFFF);

      // Write enable honoured
      we = 1'b1; wsel = 3; wd = 32'hA5A5A5A5; tick();
      we = 1'b0; wd = 32'h1; tick();
      sel1 = 3; #1;
      check("we.r3", rd1_z, 32'hA5A5A5A5);

      // Scoreboard on r9
      res = 1'b1; rsel = 9; sel1 = 9; #1;
      check("sb.pre", DW'(b1_z), 32'd0);
      tick(); res = 1'b0; #1;
      check("sb.busy1", DW'(b1_z), 32'd1);
      tick();
      check("sb.busy2", DW'(b1_z), 32'd1);
      we = 1'b1; wsel = 9; wd = 32'h55; #1;
      check("sb.wrcycle", DW'(b1_z), BYP ? 32'd0 : 32'd1);
      tick(); idle(); #1;
      check("sb.released", DW'(b1_z), 32'd0);
      check("sb.data", rd1_z, 32'h55);

      // Reserve and write r4 in the same cycle
      res = 1'b1; rsel = 4; we = 1'b1; wsel = 4; wd = 32'hCAFEF00D; tick();
      idle(); sel1 = 4; #1;
      check("sb.r4data", rd1_z, 32'hCAFEF00D);
      check("sb.r4busy", DW'(b1_z), 32'd1);

      // Bypass / collision on r2
      we = 1'b1; wsel = 2; wd = 32'h10; tick();
      wd = 32'h20; sel1 = 2; #1;
      check("byp.same", rd1_z, BYP ? 32'h20 : 32'h10);
      check("byp.busy", DW'(b1_z), 32'd0);
      tick(); idle(); #1;
      check("byp.next", rd1_z, 32'h20);

      // Mid-operation reset
      we = 1'b1; wsel = 6; wd = 32'h77; res = 1'b1; rsel = 6; tick();
      idle(); sel1 = 6; #1;
      check("mid.r6", rd1_z, 32'h77);
      check("mid.r6busy", DW'(b1_z), 32'd1);
      rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
      check("mid.ready", DW'(rdy_z), 32'd0);
      check("mid.busy", DW'(b1_z), 32'd0);
      sweep_and_check("mid");
      check("mid.r6clr", rd1_z, 32'h0);
      check("mid.r6nz", rd1_n, 32'h0);

      // Randomised traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         rst_n = ($urandom_range(0, 399) != 0);
         sel1  = raddr(); sel2 = raddr();
         rsel  = raddr(); wsel = raddr();
         res   = $urandom_range(0, 2) == 0;
         we    = $urandom_range(0, 1) == 0;
         wd    = $urandom;
         tick();
      end

      idle(); rst_n = 1'b1;
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
